// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - MIPS instruction-to-ALU decoder with ID/EX pipeline register
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (adds ex_illegal output and trap decoding)
module alu_decode_stage #(
  parameter logic [4:0] RA_REG   = 5'd31,
  parameter logic [4:0] NOP_DEST = 5'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [5:0]  ex_alu_op,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2,
  output logic [5:0]  ex_shamt,
  output logic [4:0]  ex_dest,
  output logic        ex_wb_en,
  output logic [2:0]  ex_mem_op,
  output logic [3:0]  ex_br_op,
  output logic [31:0] ex_store_data
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic        ex_illegal
`endif
);

  localparam logic [5:0] OP_SPECIAL  = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03, OP_BEQ    = 6'h04, OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06, OP_BGTZ   = 6'h07, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A, OP_SLTIU  = 6'h0B, OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI      = 6'h0F, OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20, OP_LW     = 6'h23, OP_LBU  = 6'h24;
  localparam logic [5:0] OP_SB       = 6'h28, OP_SW     = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08;
  localparam logic [5:0] F_DIV = 6'h1A, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B, F2_MUL = 6'h02;

  localparam logic [5:0] ALU_ADD = 6'd0, ALU_SUB = 6'd1, ALU_MUL = 6'd2, ALU_DIV = 6'd3;
  localparam logic [5:0] ALU_SLL = 6'd4, ALU_SRL = 6'd5, ALU_SLT = 6'd6, ALU_AND = 6'd7;
  localparam logic [5:0] ALU_OR  = 6'd8, ALU_XOR = 6'd9, ALU_NOR = 6'd10, ALU_SRA = 6'd11;
  localparam logic [5:0] ALU_LUI = 6'd12;

  localparam logic [2:0] MEM_NONE = 3'd0, MEM_LW = 3'd1, MEM_SW = 3'd2;
  localparam logic [2:0] MEM_LB   = 3'd3, MEM_SB = 3'd4, MEM_LBU = 3'd5;

  localparam logic [3:0] BR_NONE = 4'd0, BR_BEQ = 4'd1, BR_BNE = 4'd2, BR_BGEZ = 4'd3;
  localparam logic [3:0] BR_BGTZ = 4'd4, BR_BLEZ = 4'd5, BR_BLTZ = 4'd6, BR_J = 4'd7;
  localparam logic [3:0] BR_JAL  = 4'd8, BR_JR = 4'd9;

  logic [5:0]  opcode, funct;
  logic [4:0]  rt_idx, rd_idx;
  logic [31:0] imm_sx, imm_zx;
  logic        unused_rs_field;

  assign opcode = id_instr[31:26];
  assign funct  = id_instr[5:0];
  assign rt_idx = id_instr[20:16];
  assign rd_idx = id_instr[15:11];
  assign imm_sx = {{16{id_instr[15]}}, id_instr[15:0]};
  assign imm_zx = {16'h0000, id_instr[15:0]};
  // rs arrives already read and forwarded, so its index field is not needed here
  assign unused_rs_field = ^id_instr[25:21];

  logic [5:0]  d_op;
  logic [31:0] d_op1, d_op2, d_sd;
  logic [4:0]  d_dest;
  logic        d_wb, d_ill, d_wb_en;
  logic [2:0]  d_mem;
  logic [3:0]  d_br;

  // Decode the ID-stage instruction into ALU op, operands and side-band control
  always_comb begin
    d_op   = ALU_SLL;
    d_op1  = '0;
    d_op2  = '0;
    d_dest = NOP_DEST;
    d_wb   = 1'b0;
    d_mem  = MEM_NONE;
    d_br   = BR_NONE;
    d_sd   = '0;
    d_ill  = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        d_op1  = id_rs_data;
        d_op2  = id_rt_data;
        d_dest = rd_idx;
        d_wb   = 1'b1;
        case (funct)
          F_ADD, F_ADDU: d_op = ALU_ADD;
          F_SUB, F_SUBU: d_op = ALU_SUB;
          F_AND:         d_op = ALU_AND;
          F_OR:          d_op = ALU_OR;
          F_XOR:         d_op = ALU_XOR;
          F_NOR:         d_op = ALU_NOR;
          F_SLT, F_SLTU: d_op = ALU_SLT;
          F_SLL: begin d_op = ALU_SLL; d_op1 = '0; end
          F_SRL: begin d_op = ALU_SRL; d_op1 = '0; end
          F_SRA: begin d_op = ALU_SRA; d_op1 = '0; end
          F_DIV: begin
            d_op = ALU_DIV;
`ifdef DECODE_ILLEGAL_TRAP_EN
            if (id_rt_data == '0) d_ill = 1'b1;
`endif
          end
          F_JR: begin
            d_op   = ALU_ADD;
            d_op2  = '0;
            d_dest = NOP_DEST;
            d_wb   = 1'b0;
            d_br   = BR_JR;
          end
          default: d_ill = 1'b1;
        endcase
      end
      OP_SPECIAL2: begin
        if (funct == F2_MUL) begin
          d_op   = ALU_MUL;
          d_op1  = id_rs_data;
          d_op2  = id_rt_data;
          d_dest = rd_idx;
          d_wb   = 1'b1;
        end else begin
          d_ill = 1'b1;
        end
      end
      OP_REGIMM: begin
        d_op  = ALU_SUB;
        d_op1 = id_rs_data;
        if (rt_idx == 5'd1)      d_br = BR_BGEZ;
        else if (rt_idx == 5'd0) d_br = BR_BLTZ;
        else                     d_ill = 1'b1;
      end
      OP_J: d_br = BR_J;
      OP_JAL: begin
        d_op   = ALU_ADD;
        d_op1  = id_pc;
        d_op2  = 32'd8;
        d_dest = RA_REG;
        d_wb   = 1'b1;
        d_br   = BR_JAL;
      end
      OP_BEQ, OP_BNE: begin
        d_op  = ALU_SUB;
        d_op1 = id_rs_data;
        d_op2 = id_rt_data;
        d_br  = (opcode == OP_BEQ) ? BR_BEQ : BR_BNE;
      end
      OP_BLEZ, OP_BGTZ: begin
        d_op  = ALU_SUB;
        d_op1 = id_rs_data;
        d_br  = (opcode == OP_BLEZ) ? BR_BLEZ : BR_BGTZ;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ORI, OP_LUI: begin
        d_op1  = id_rs_data;
        d_dest = rt_idx;
        d_wb   = 1'b1;
        case (opcode)
          OP_ADDIU: begin d_op = ALU_ADD; d_op2 = imm_sx; end
          OP_ORI:   begin d_op = ALU_OR;  d_op2 = imm_zx; end
          OP_LUI:   begin d_op = ALU_LUI; d_op2 = imm_zx; end
          default:  begin d_op = ALU_SLT; d_op2 = imm_sx; end
        endcase
      end
      OP_LW, OP_LB, OP_LBU: begin
        d_op   = ALU_ADD;
        d_op1  = id_rs_data;
        d_op2  = imm_sx;
        d_dest = rt_idx;
        d_wb   = 1'b1;
        d_mem  = (opcode == OP_LW) ? MEM_LW : ((opcode == OP_LB) ? MEM_LB : MEM_LBU);
      end
      OP_SW, OP_SB: begin
        d_op  = ALU_ADD;
        d_op1 = id_rs_data;
        d_op2 = imm_sx;
        d_sd  = id_rt_data;
        d_mem = (opcode == OP_SW) ? MEM_SW : MEM_SB;
      end
      default: d_ill = 1'b1;
    endcase
    // Anything unsupported (or trapped) degrades to a side-effect-free nop
    if (d_ill) begin
      d_op   = ALU_SLL;
      d_op1  = '0;
      d_op2  = '0;
      d_dest = NOP_DEST;
      d_wb   = 1'b0;
      d_mem  = MEM_NONE;
      d_br   = BR_NONE;
      d_sd   = '0;
    end
  end

  assign d_wb_en  = d_wb & (d_dest != NOP_DEST);
  assign id_ready = ~ex_stall | ~ex_valid;

  // ID/EX register: reset beats flush, flush beats accept, stall holds everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_alu_op     <= '0;
      ex_op1        <= '0;
      ex_op2        <= '0;
      ex_shamt      <= '0;
      ex_dest       <= '0;
      ex_wb_en      <= 1'b0;
      ex_mem_op     <= '0;
      ex_br_op      <= '0;
      ex_store_data <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      ex_illegal    <= 1'b0;
`endif
    end else begin
      if (flush)         ex_valid <= 1'b0;
      else if (id_ready) ex_valid <= id_valid;
      if (id_valid && id_ready) begin
        ex_alu_op     <= d_op;
        ex_op1        <= d_op1;
        ex_op2        <= d_op2;
        ex_shamt      <= {1'b0, id_instr[10:6]};
        ex_dest       <= d_dest;
        ex_wb_en      <= d_wb_en;
        ex_mem_op     <= d_mem;
        ex_br_op      <= d_br;
        ex_store_data <= d_sd;
`ifdef DECODE_ILLEGAL_TRAP_EN
        ex_illegal    <= d_ill;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - scoreboard bench for alu_decode_stage with a mnemonic-level model
module tb_alu_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, id_valid, id_ready, ex_stall, flush, ex_valid, ex_wb_en;
  logic [31:0] id_instr, id_pc, id_rs_data, id_rt_data, ex_op1, ex_op2, ex_store_data;
  logic [5:0]  ex_alu_op, ex_shamt;
  logic [4:0]  ex_dest;
  logic [2:0]  ex_mem_op;
  logic [3:0]  ex_br_op;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        ex_illegal;
`endif

  alu_decode_stage #(.RA_REG(5'd31), .NOP_DEST(5'd0)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .ex_stall(ex_stall), .flush(flush), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_shamt(ex_shamt), .ex_dest(ex_dest),
    .ex_wb_en(ex_wb_en), .ex_mem_op(ex_mem_op), .ex_br_op(ex_br_op),
    .ex_store_data(ex_store_data)
`ifdef DECODE_ILLEGAL_TRAP_EN
    , .ex_illegal(ex_illegal)
`endif
  );

  typedef enum int {
    I_ADD, I_ADDU, I_SUB, I_SUBU, I_AND, I_OR, I_XOR, I_NOR, I_SLT, I_SLTU,
    I_SLL, I_SRL, I_SRA, I_MUL, I_DIV, I_ADDIU, I_SLTI, I_SLTIU, I_ORI, I_LUI,
    I_LW, I_LB, I_LBU, I_SW, I_SB, I_BEQ, I_BNE, I_BGEZ, I_BGTZ, I_BLEZ, I_BLTZ,
    I_J, I_JAL, I_JR, I_NOP, I_ILL
  } mn_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] op1, op2, sd;
    logic [5:0]  shamt;
    logic [4:0]  dest;
    logic        wb, ill;
    logic [2:0]  mem;
    logic [3:0]  br;
    logic        c_op, c_op1, c_dest, c_sd;
  } exp_t;

  exp_t sbq[$];
  int   n_total = 0;
  int   n_pass  = 0;
  logic m_valid = 1'b0;
  logic mon_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] enc(input mn_t m, input logic [4:0] rs, rt, rd, sh,
                                      input logic [15:0] imm, input logic [25:0] junk);
    case (m)
      I_ADD:   return {6'h00, rs, rt, rd, sh, 6'h20};
      I_ADDU:  return {6'h00, rs, rt, rd, sh, 6'h21};
      I_SUB:   return {6'h00, rs, rt, rd, sh, 6'h22};
      I_SUBU:  return {6'h00, rs, rt, rd, sh, 6'h23};
      I_AND:   return {6'h00, rs, rt, rd, sh, 6'h24};
      I_OR:    return {6'h00, rs, rt, rd, sh, 6'h25};
      I_XOR:   return {6'h00, rs, rt, rd, sh, 6'h26};
      I_NOR:   return {6'h00, rs, rt, rd, sh, 6'h27};
      I_SLT:   return {6'h00, rs, rt, rd, sh, 6'h2A};
      I_SLTU:  return {6'h00, rs, rt, rd, sh, 6'h2B};
      I_SLL:   return {6'h00, 5'd0, rt, rd, sh, 6'h00};
      I_SRL:   return {6'h00, 5'd0, rt, rd, sh, 6'h02};
      I_SRA:   return {6'h00, 5'd0, rt, rd, sh, 6'h03};
      I_MUL:   return {6'h1C, rs, rt, rd, 5'd0, 6'h02};
      I_DIV:   return {6'h00, rs, rt, rd, 5'd0, 6'h1A};
      I_ADDIU: return {6'h09, rs, rt, imm};
      I_SLTI:  return {6'h0A, rs, rt, imm};
      I_SLTIU: return {6'h0B, rs, rt, imm};
      I_ORI:   return {6'h0D, rs, rt, imm};
      I_LUI:   return {6'h0F, 5'd0, rt, imm};
      I_LW:    return {6'h23, rs, rt, imm};
      I_LB:    return {6'h20, rs, rt, imm};
      I_LBU:   return {6'h24, rs, rt, imm};
      I_SW:    return {6'h2B, rs, rt, imm};
      I_SB:    return {6'h28, rs, rt, imm};
      I_BEQ:   return {6'h04, rs, rt, imm};
      I_BNE:   return {6'h05, rs, rt, imm};
      I_BGEZ:  return {6'h01, rs, 5'd1, imm};
      I_BLTZ:  return {6'h01, rs, 5'd0, imm};
      I_BGTZ:  return {6'h07, rs, 5'd0, imm};
      I_BLEZ:  return {6'h06, rs, 5'd0, imm};
      I_J:     return {6'h02, junk};
      I_JAL:   return {6'h03, junk};
      I_JR:    return {6'h00, rs, 15'd0, 6'h08};
      I_NOP:   return 32'h0000_0000;
      default: return {6'h3F, junk};
    endcase
  endfunction

  // What the EX stage should see for a mnemonic, from the instruction-set rules
  function automatic exp_t model(input mn_t m, input logic [31:0] w, pc, rsd, rtd);
    exp_t e;
    logic [31:0] sx, zx;
    logic        has_wb;
    sx = {{16{w[15]}}, w[15:0]};
    zx = {16'h0, w[15:0]};
    e = '{op: 6'd0, op1: rsd, op2: rtd, sd: 32'd0, shamt: {1'b0, w[10:6]}, dest: w[15:11],
          wb: 1'b0, ill: 1'b0, mem: 3'd0, br: 4'd0, c_op: 1'b1, c_op1: 1'b1,
          c_dest: 1'b1, c_sd: 1'b0};
    has_wb = 1'b0;
    case (m)
      I_ADD, I_ADDU: begin e.op = 0; has_wb = 1; end
      I_SUB, I_SUBU: begin e.op = 1; has_wb = 1; end
      I_AND:  begin e.op = 7;  has_wb = 1; end
      I_OR:   begin e.op = 8;  has_wb = 1; end
      I_XOR:  begin e.op = 9;  has_wb = 1; end
      I_NOR:  begin e.op = 10; has_wb = 1; end
      I_SLT, I_SLTU: begin e.op = 6; has_wb = 1; end
      I_SLL:  begin e.op = 4;  e.op1 = 0; has_wb = 1; end
      I_SRL:  begin e.op = 5;  e.op1 = 0; has_wb = 1; end
      I_SRA:  begin e.op = 11; e.op1 = 0; has_wb = 1; end
      I_NOP:  begin e.op = 4;  e.op1 = 0; e.dest = 0; end
      I_MUL:  begin e.op = 2;  has_wb = 1; end
      I_DIV: begin
        e.op = 3; has_wb = 1;
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (rtd == 0) begin e.ill = 1; has_wb = 0; e.c_op = 0; e.c_op1 = 0; e.c_dest = 0; end
`endif
      end
      I_ADDIU: begin e.op = 0; e.op2 = sx; e.dest = w[20:16]; has_wb = 1; end
      I_SLTI, I_SLTIU: begin e.op = 6; e.op2 = sx; e.dest = w[20:16]; has_wb = 1; end
      I_ORI:  begin e.op = 8;  e.op2 = zx; e.dest = w[20:16]; has_wb = 1; end
      I_LUI:  begin e.op = 12; e.op2 = zx; e.dest = w[20:16]; has_wb = 1; e.c_op1 = 0; end
      I_LW, I_LB, I_LBU: begin
        e.op = 0; e.op2 = sx; e.dest = w[20:16]; has_wb = 1;
        e.mem = (m == I_LW) ? 3'd1 : ((m == I_LB) ? 3'd3 : 3'd5);
      end
      I_SW, I_SB: begin
        e.op = 0; e.op2 = sx; e.c_dest = 0; e.c_sd = 1; e.sd = rtd;
        e.mem = (m == I_SW) ? 3'd2 : 3'd4;
      end
      I_BEQ:  begin e.op = 1; e.br = 1; e.c_dest = 0; end
      I_BNE:  begin e.op = 1; e.br = 2; e.c_dest = 0; end
      I_BGEZ: begin e.op = 1; e.op2 = 0; e.br = 3; e.c_dest = 0; end
      I_BGTZ: begin e.op = 1; e.op2 = 0; e.br = 4; e.c_dest = 0; end
      I_BLEZ: begin e.op = 1; e.op2 = 0; e.br = 5; e.c_dest = 0; end
      I_BLTZ: begin e.op = 1; e.op2 = 0; e.br = 6; e.c_dest = 0; end
      I_J:    begin e.br = 7; e.c_op = 0; e.c_op1 = 0; e.c_dest = 0; end
      I_JAL:  begin e.op = 0; e.op1 = pc; e.op2 = 8; e.dest = 31; e.br = 8; has_wb = 1; end
      I_JR:   begin e.op = 0; e.op2 = 0; e.br = 9; e.c_dest = 0; end
      default: begin
        e.c_op = 0; e.c_op1 = 0; e.c_dest = 0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        e.ill = 1;
`endif
      end
    endcase
    e.wb = has_wb && (e.dest != 0);
    return e;
  endfunction

  // One clock of stimulus; the model tracks what the EX register should hold
  task automatic step(input mn_t m, input logic v, input logic [31:0] w, pc, rsd, rtd,
                      input logic stall, fl, rstn);
    exp_t e;
    logic rdy;
    rst_n = rstn; id_valid = v; id_instr = w; id_pc = pc;
    id_rs_data = rsd; id_rt_data = rtd; ex_stall = stall; flush = fl;
    rdy = !m_valid || !stall;
    e = model(m, w, pc, rsd, rtd);
    @(posedge clk);
    if (!rstn) begin
      m_valid = 0;
      sbq.delete();
    end else if (fl) begin
      if (m_valid && stall && sbq.size() > 0) void'(sbq.pop_front());
      m_valid = 0;
    end else if (rdy) begin
      m_valid = v;
      if (v) sbq.push_back(e);
    end
    #1;
  endtask

  // Monitor: an instruction is consumed when ex_valid is high and EX is not stalled
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
      chk("id_ready", {31'd0, id_ready}, {31'd0, (!m_valid || !ex_stall)});
      if (ex_valid && !ex_stall) begin
        if (sbq.size() == 0) begin
          chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
          e = sbq.pop_front();
          if (e.c_op) begin
            chk("alu_op", {26'd0, ex_alu_op}, {26'd0, e.op});
            chk("op2", ex_op2, e.op2);
          end
          if (e.c_op1)  chk("op1", ex_op1, e.op1);
          if (e.c_dest) chk("dest", {27'd0, ex_dest}, {27'd0, e.dest});
          if (e.c_sd)   chk("store_data", ex_store_data, e.sd);
          chk("shamt", {26'd0, ex_shamt}, {26'd0, e.shamt});
          chk("wb_en", {31'd0, ex_wb_en}, {31'd0, e.wb});
          chk("mem_op", {29'd0, ex_mem_op}, {29'd0, e.mem});
          chk("br_op", {28'd0, ex_br_op}, {28'd0, e.br});
`ifdef DECODE_ILLEGAL_TRAP_EN
          chk("illegal", {31'd0, ex_illegal}, {31'd0, e.ill});
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, rt_d;
    mn_t m;
    rst_n = 0; id_valid = 0; id_instr = 0; id_pc = 0; id_rs_data = 0; id_rt_data = 0;
    ex_stall = 0; flush = 0;

    step(I_ADD, 1, enc(I_ADD, 1, 2, 3, 0, 0, 0), 32'h100, 32'h11, 32'h22, 0, 0, 0);
    step(I_ADD, 1, enc(I_ADD, 1, 2, 3, 0, 0, 0), 32'h100, 32'h11, 32'h22, 0, 0, 0);
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_alu_op", {26'd0, ex_alu_op}, 32'd0);
    chk("rst_op1", ex_op1, 32'd0);
    chk("rst_op2", ex_op2, 32'd0);
    chk("rst_shamt", {26'd0, ex_shamt}, 32'd0);
    chk("rst_dest", {27'd0, ex_dest}, 32'd0);
    chk("rst_wb_en", {31'd0, ex_wb_en}, 32'd0);
    chk("rst_mem_op", {29'd0, ex_mem_op}, 32'd0);
    chk("rst_br_op", {28'd0, ex_br_op}, 32'd0);
    chk("rst_store_data", ex_store_data, 32'd0);
    chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
    mon_en = 1;

    step(I_ADDIU, 1, enc(I_ADDIU, 4, 5, 0, 0, 16'hFFFF, 0), 32'h104, 32'h10, 32'h7, 0, 0, 1);
    step(I_LUI, 1, enc(I_LUI, 0, 2, 0, 0, 16'h1234, 0), 32'h108, 32'h5, 32'h6, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      step(I_ADDU, 1, enc(I_ADDU, 6, 0, 9, 0, 0, 0), 32'h10C, 32'hABCD, 32'h0, 1, 0, 1);
    step(I_ADDU, 1, enc(I_ADDU, 6, 0, 9, 0, 0, 0), 32'h10C, 32'hABCD, 32'h0, 0, 0, 1);
    step(I_JAL, 1, enc(I_JAL, 0, 0, 0, 0, 0, 26'h100), 32'h400, 32'h1, 32'h2, 0, 0, 1);
    step(I_JAL, 1, enc(I_JAL, 0, 0, 0, 0, 0, 26'h100), 32'h400, 32'h1, 32'h2, 0, 1, 1);
    step(I_JAL, 1, enc(I_JAL, 0, 0, 0, 0, 0, 26'h3), 32'hFFFF_FFFC, 0, 0, 0, 0, 1);
    step(I_SRA, 1, enc(I_SRA, 0, 7, 3, 4, 0, 0), 32'h110, 32'h55, 32'h8000_0000, 0, 0, 1);
    step(I_NOP, 1, 32'h0, 32'h114, 32'h9, 32'h3, 0, 0, 1);
    step(I_ILL, 1, enc(I_ILL, 0, 0, 0, 0, 0, 26'h2AAAAAA), 32'h118, 32'h9, 32'h3, 0, 0, 1);
    step(I_DIV, 1, enc(I_DIV, 1, 2, 3, 0, 0, 0), 32'h11C, 32'h64, 32'h0, 0, 0, 1);
    step(I_SW, 1, enc(I_SW, 1, 2, 0, 0, 16'h8000, 0), 32'h120, 32'h1000, 32'hCAFE, 1, 0, 1);
    step(I_SW, 0, 32'h0, 32'h124, 0, 0, 1, 0, 1);
    step(I_SW, 0, 32'h0, 32'h124, 0, 0, 1, 0, 0);
    step(I_NOP, 0, 32'h0, 32'h0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 500; i++) begin
      m = mn_t'($urandom_range(0, 35));
      r = $urandom();
      rt_d = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
      step(m, ($urandom_range(0, 3) != 0),
           enc(m, r[4:0], r[9:5], r[14:10], r[19:15], r[31:16], r[25:0]),
           $urandom(), $urandom(), rt_d,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 49) != 0));
    end

    for (int i = 0; i < 3; i++) step(I_NOP, 0, 32'h0, 32'h0, 0, 0, 0, 0, 1);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
